mod_dbl_seq: RTL and testbench

Sequential modular doubler for the Kyber datapath (q = 3329): accepts one coefficient and a shift count k, and returns y = x·2^k mod q after k iterative double-and-reduce steps. It is the inverse of the halving stage in the GS/INTT path. Its uses are undoing accumulated 1/2 scaling and applying power-of-two constant scaling to coefficients before they re-enter the forward NTT lanes. Valid/ready handshakes on both sides; one coefficient in flight at a time.

---
 rtl/mod_dbl_seq.sv | 124 ++++++++++++
 tb/tb_mod_dbl_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_dbl_seq.sv
// mod_dbl_seq -- sequential modular doubler for the Kyber datapath (q = 3329).
//
// Accepts one coefficient x and a shift count k, then performs k iterative
// double-and-reduce steps to return y = x * 2^k mod Q. Used to undo
// accumulated 1/2 scaling from the GS/INTT halving stage and to apply
// power-of-two constant scaling before coefficients re-enter the NTT lanes.
// One coefficient is in flight at a time.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous active-low reset
//   in_valid  in   1   input coefficient valid
//   in_ready  out  1   block can accept input (high only when idle)
//   in_x      in   DW  input coefficient, 0..4095 accepted
//   in_k      in   KW  number of doublings
//   out_valid out  1   result valid, held until out_ready
//   out_ready in   1   downstream accepts result
//   out_y     out  DW  result, always in 0..Q-1
//   busy      out  1   block is not idle
module mod_dbl_seq #(
  parameter int unsigned Q  = 3329,
  parameter int unsigned DW = 12,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [DW-1:0] QN   = Q[DW-1:0];
  localparam logic [DW:0]   QW   = Q[DW:0];
  localparam logic [KW-1:0] KONE = {{(KW-1){1'b0}}, 1'b1};

  state_e        state_q;
  logic [DW-1:0] acc_q;
  logic [KW-1:0] cnt_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [DW:0]   dbl;
  logic [DW:0]   dbl_sub;
  logic [DW-1:0] dbl_red_d;
  logic [DW-1:0] load_red_d;

  // acc < Q holds after load, so the doubled value is < 2Q and a single
  // conditional subtract fully reduces it. The load path likewise needs only
  // one subtract because 4095 - Q < Q.
  always_comb begin
    dbl        = {acc_q, 1'b0};
    dbl_sub    = dbl - QW;
    dbl_red_d  = (dbl >= QW) ? dbl_sub[DW-1:0] : dbl[DW-1:0];
    load_red_d = (in_x >= QN) ? (in_x - QN) : in_x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= load_red_d;
            cnt_q      <= in_k;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_k != '0) begin
              state_q <= RUN;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= dbl_red_d;
          cnt_q <= cnt_q - KONE;
          if (cnt_q == KONE) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod_dbl_seq.sv
// Self-checking bench for mod_dbl_seq. Expected results come from the
// arithmetic definition y = x * 2^k mod 3329.
module tb_mod_dbl_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_x;
  logic [3:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_y;
  logic        busy;

  int asserts = 0;
  int fails   = 0;

  mod_dbl_seq #(.Q(3329), .DW(12), .KW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_k     (in_k),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned ref_dbl(input int unsigned x, input int unsigned k);
    return (x * (32'd1 << k)) % 32'd3329;
  endfunction

  // Drives one input when the block is ready and waits (bounded) for
  // out_valid. lat counts edges from the accept edge (accept edge = 1).
  task automatic start_txn(input logic [11:0] x, input logic [3:0] k,
                           output logic [11:0] y, output int lat);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; in_x = x; in_k = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = 12'($urandom);
    in_k = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    y = out_y;
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    asserts++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_y !== 12'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b ready=%b busy=%b y=%0d, want 0 1 0 0",
               out_valid, in_ready, busy, out_y);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [11:0] vx [10] = '{12'd1, 12'd5, 12'd1665, 12'd2497, 12'd3328,
                             12'd1, 12'd1, 12'd3329, 12'd4095, 12'd3328};
    logic [3:0]  vk [10] = '{4'd1, 4'd3, 4'd1, 4'd2, 4'd1,
                             4'd12, 4'd15, 4'd0, 4'd0, 4'd15};
    logic [11:0] y;
    int lat;
    for (int i = 0; i < 10; i++) begin
      start_txn(vx[i], vk[i], y, lat);
      asserts++;
      if (out_valid !== 1'b1 || y !== 12'(ref_dbl(vx[i], vk[i]))) begin
        fails++;
        $display("FAIL vec%0d_value: x=%0d k=%0d got y=%0d valid=%b, want y=%0d valid=1",
                 i, vx[i], vk[i], y, out_valid, ref_dbl(vx[i], vk[i]));
      end
      asserts++;
      if (lat !== int'(vk[i]) + 1) begin
        fails++;
        $display("FAIL vec%0d_latency: got %0d cycles, want %0d", i, lat, int'(vk[i]) + 1);
      end
      finish_txn();
    end
  endtask

  task automatic test_spec_constants();
    logic [11:0] y;
    int lat;
    start_txn(12'd1, 4'd15, y, lat);
    asserts++;
    if (y !== 12'd2807 || lat !== 16) begin
      fails++;
      $display("FAIL max_k: got y=%0d lat=%0d, want y=2807 lat=16", y, lat);
    end
    finish_txn();
    start_txn(12'd4095, 4'd0, y, lat);
    asserts++;
    if (y !== 12'd766 || lat !== 1) begin
      fails++;
      $display("FAIL k0_wrap: got y=%0d lat=%0d, want y=766 lat=1", y, lat);
    end
    finish_txn();
  endtask

  task automatic test_backpressure();
    logic [11:0] y;
    int lat;
    start_txn(12'd7, 4'd2, y, lat);
    for (int i = 0; i < 5; i++) begin
      asserts++;
      if (out_valid !== 1'b1 || out_y !== 12'd28 || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold%0d: got valid=%b y=%0d ready=%b busy=%b, want 1 28 0 1",
                 i, out_valid, out_y, in_ready, busy);
      end
      @(posedge clk); #1;
    end
    finish_txn();
    asserts++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: got valid=%b ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [11:0] y;
    int lat;
    in_valid = 1'b1; in_x = 12'd1; in_k = 4'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    asserts++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: got valid=%b ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
    start_txn(12'd3, 4'd1, y, lat);
    asserts++;
    if (y !== 12'd6 || lat !== 2) begin
      fails++;
      $display("FAIL after_reset_txn: got y=%0d lat=%0d, want y=6 lat=2", y, lat);
    end
    finish_txn();
  endtask

  task automatic test_back_to_back();
    int unsigned exp_q[$];
    int unsigned e;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 60000) begin
      in_x = 12'($urandom);
      in_k = 4'($urandom);
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_dbl(in_x, in_k));
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        asserts++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra: got unexpected y=%0d, want no result", out_y);
        end else begin
          e = exp_q.pop_front();
          if (out_y !== 12'(e)) begin
            fails++;
            $display("FAIL b2b_value%0d: got y=%0d, want %0d", got, out_y, e);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    asserts++;
    if (got !== 1000 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: got %0d results (%0d pending), want 1000 (0 pending)",
               got, exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_k      = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_vectors();
    test_spec_constants();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
